pipe_skid_stage: RTL and testbench

Two-entry valid/ready pipeline stage that carries a WIDTH-bit word between adjacent datapath stages at full throughput. `in_ready` is driven from flops only, so no combinational path runs from `out_ready` back to `in_ready`; this breaks the backpressure timing path across stage boundaries. Storage is two enabled, reset-to-zero data registers (main and skid) plus a 2-bit occupancy state machine. A synchronous flush discards all buffered words.

---
 rtl/pipe_skid_stage.sv | 125 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage with in_ready decoded purely from registered state.
// Optional saturating stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_p0;
  state_t           state_nxt;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic [WIDTH-1:0] main_p0;
  logic [WIDTH-1:0] skid_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p0)
      EMPTY: begin
        if (in_valid) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_valid) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over every transition; data registers simply keep stale words.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_comb begin
    out_valid = (state_p0 != EMPTY);
    in_ready  = (state_p0 != FULL);
    out_data  = main_p0;
  end

  // Stage p0: main and skid payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (load_main_in) begin
        main_p0 <= in_data;
      end else if (load_main_skid) begin
        main_p0 <= skid_p0;
      end
      if (load_skid) begin
        skid_p0 <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_p0 <= 16'd0;
    end else if (flush) begin
      stall_cnt_p0 <= 16'd0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_p0 <= sat_inc16(stall_cnt_p0);
    end
  end

  assign stall_cnt = stall_cnt_p0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage: reset, streaming, backpressure,
// flush, asynchronous reset and (with PIPE_SKID_STALL_CNT_EN) stall counter saturation.
module tb_pipe_skid_stage;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks;
  int failures;

  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=0000", out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp      = 16'(i + 1);
      in_valid = 1'b1;
      in_data  = exp;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stream_valid[%0d] got=%0b exp=1", i, out_valid);
      end
      checks++;
      if (out_data !== exp) begin
        failures++;
        $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, exp);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    in_valid  = 1'b1;
    in_data   = 16'h00A1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 16'h00A1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first got=%h/%0b exp=00a1/1", out_data, in_ready);
    end
    out_ready = 1'b0;
    in_data   = 16'h00A2;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got=%0b/%h/%0b exp=1/00a1/0", out_valid, out_data, in_ready);
    end
    in_data = 16'h00A3;
    step();
    checks++;
    if (out_data !== 16'h00A1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got=%h/%0b exp=00a1/0", out_data, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 16'h00A2 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_second got=%h/%0b exp=00a2/1", out_data, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A3) begin
      failures++;
      $display("FAIL bp_third got=%0b/%h exp=1/00a3", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    out_ready = 1'b0;
    step();
    in_data = 16'h0022;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 16'h0011) begin
      failures++;
      $display("FAIL flush_setup got=%0b/%h exp=0/0011", in_ready, out_data);
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty got=%0b/%0b exp=0/1", out_valid, in_ready);
    end
    in_valid  = 1'b1;
    in_data   = 16'h0033;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0033) begin
      failures++;
      $display("FAIL flush_next got=%0b/%h exp=1/0033", out_valid, out_data);
    end
    // Beat offered in the same cycle as flush must be discarded.
    in_data = 16'h0044;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop_in got=%0b exp=0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stay_empty got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0055) begin
      failures++;
      $display("FAIL areset_setup got=%0b/%h exp=1/0055", out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_immediate got=%0b/%h/%0b exp=0/0000/1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      failures++;
      $display("FAIL areset_lost got=%0b/%h exp=0/0000", out_valid, out_data);
    end
  endtask

`ifdef PIPE_SKID_STALL_CNT_EN
  task automatic test_stall_cnt();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_clear got=%h exp=0000", stall_cnt);
    end
    in_valid = 1'b1;
    in_data  = 16'h0077;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_count got=%h exp=0003", stall_cnt);
    end
    repeat (70000) step();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_saturate got=%h exp=ffff", stall_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_flush got=%h exp=0000", stall_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef PIPE_SKID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
